// File: rtl/spad_frontend_pkg.sv
// Shared constants and event-state encoding for the SPAD pixel front end.
// The state encoding exposes the front end's event state for verification.
package spad_frontend_pkg;
  localparam int NUM_SPAD = 16;
  localparam int HIT_W    = 5;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    TRIGGERED = 2'd1,
    GATE_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/spad_sync.sv
// N-stage flop synchroniser with asynchronous active-low clear.
// Also used as a reset-release synchroniser by tying d high.
module spad_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spad_frontend.sv
// SPAD pixel front end: photon edge -> latched trigger, bounded time gate and hit count.
// trig/hit_cnt live in the photon clock domain; the gate length is timed on clk.
module spad_frontend
  import spad_frontend_pkg::*;
#(
  parameter int GATE_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_auto,
  input  logic                photon,
  input  logic [NUM_SPAD-1:0] spaden,
  output logic                trig,
  output logic                time_gate,
  output logic [HIT_W-1:0]    hit_cnt
);

  localparam logic [3:0] GATE_LIM = 4'(GATE_CYCLES);

  function automatic logic [HIT_W-1:0] popcount(input logic [NUM_SPAD-1:0] v);
    logic [HIT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SPAD; i++) begin
      c = c + HIT_W'(v[i]);
    end
    return c;
  endfunction

  // Photon edge is the clock here, so trig carries no clk quantisation.
  always_ff @(posedge photon or negedge rst_auto) begin
    if (!rst_auto) begin
      trig    <= 1'b0;
      hit_cnt <= '0;
    end else if (!trig && (|spaden)) begin
      trig    <= 1'b1;
      hit_cnt <= popcount(spaden);
    end
  end

  logic rst_clk_n;
  logic trig_s;
  logic gate_done;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  state_t state;

  spad_sync #(.STAGES(2)) u_rst_sync (
    .clk   (clk),
    .clr_n (rst_auto),
    .d     (1'b1),
    .q     (rst_clk_n)
  );

  spad_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (
    .clk   (clk),
    .clr_n (rst_clk_n),
    .d     (trig),
    .q     (trig_s)
  );

  assign cnt_nxt = cnt + 4'd1;

  // gate_done sets on the same edge the count reaches the limit, then holds.
  always_ff @(posedge clk or negedge rst_clk_n) begin
    if (!rst_clk_n) begin
      cnt       <= 4'd0;
      gate_done <= 1'b0;
    end else if (trig_s && !gate_done) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == GATE_LIM) begin
        gate_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state = ARMED;
    if (trig) begin
      state = gate_done ? GATE_DONE : TRIGGERED;
    end
  end

  assign time_gate = (state == TRIGGERED);

endmodule

// File: tb/tb_spad_frontend.sv
// Directed bench for spad_frontend: table of single events plus hand-written
// corner sequences (ignored photons, retrigger, mid-gate reset, longer gate).
module tb_spad_frontend;

  logic        clk;
  logic        rst_auto, photon;
  logic [15:0] spaden;
  logic        trig, time_gate;
  logic [4:0]  hit_cnt;

  logic        rst4, photon4;
  logic [15:0] spaden4;
  logic        trig4, time_gate4;
  logic [4:0]  hit_cnt4;

  int checks = 0;
  int errors = 0;

  spad_frontend dut (
    .clk       (clk),
    .rst_auto  (rst_auto),
    .photon    (photon),
    .spaden    (spaden),
    .trig      (trig),
    .time_gate (time_gate),
    .hit_cnt   (hit_cnt)
  );

  spad_frontend #(.GATE_CYCLES(4), .SYNC_STAGES(2)) dut4 (
    .clk       (clk),
    .rst_auto  (rst4),
    .photon    (photon4),
    .spaden    (spaden4),
    .trig      (trig4),
    .time_gate (time_gate4),
    .hit_cnt   (hit_cnt4)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct {
    logic [15:0] en;
    logic        exp_trig;
    int          exp_hit;
    int          exp_width;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    rst_auto = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_auto = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Raise photon mid-period, then drop it a few cycles later from the caller.
  task automatic photon_rise(input logic [15:0] en);
    @(negedge clk);
    spaden = en;
    photon = 1'b1;
    #1;
  endtask

  task automatic photon_fall();
    @(negedge clk);
    photon = 1'b0;
  endtask

  // Count clk edges until time_gate falls; bounded.
  task automatic gate_width(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!time_gate) break;
    end
  endtask

  initial begin
    int w;
    rst_auto = 1'b0; photon = 1'b0; spaden = '0;
    rst4 = 1'b0; photon4 = 1'b0; spaden4 = '0;

    vecs[0] = '{16'h000F, 1'b1,  4, 3};
    vecs[1] = '{16'h00FF, 1'b1,  8, 3};
    vecs[2] = '{16'h0FFF, 1'b1, 12, 3};
    vecs[3] = '{16'hFFFF, 1'b1, 16, 3};
    vecs[4] = '{16'h0000, 1'b0,  0, 0};
    vecs[5] = '{16'h8001, 1'b1,  2, 3};
    vecs[6] = '{16'h0003, 1'b1,  2, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset trig", int'(trig), 0);
    chk("reset time_gate", int'(time_gate), 0);
    chk("reset hit_cnt", int'(hit_cnt), 0);
    rst_auto = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      photon_rise(vecs[i].en);
      chk($sformatf("v%0d trig at edge", i), int'(trig), int'(vecs[i].exp_trig));
      chk($sformatf("v%0d gate at edge", i), int'(time_gate), int'(vecs[i].exp_trig));
      chk($sformatf("v%0d hit_cnt", i), int'(hit_cnt), vecs[i].exp_hit);
      if (vecs[i].exp_trig) begin
        gate_width(w);
        chk($sformatf("v%0d gate width", i), w, vecs[i].exp_width);
      end else begin
        repeat (5) @(posedge clk);
        #1;
        chk($sformatf("v%0d gate stays low", i), int'(time_gate), 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d trig holds", i), int'(trig), int'(vecs[i].exp_trig));
      chk($sformatf("v%0d hit holds", i), int'(hit_cnt), vecs[i].exp_hit);
      photon_fall();
      #1 rst_auto = 1'b0;
      #1;
      chk($sformatf("v%0d rst trig", i), int'(trig), 0);
      chk($sformatf("v%0d rst gate", i), int'(time_gate), 0);
      chk($sformatf("v%0d rst hit", i), int'(hit_cnt), 0);
      do_reset();
    end

    // Ignored empty-mask photon followed by a valid one, no reset between.
    photon_rise(16'h0000);
    chk("empty trig", int'(trig), 0);
    chk("empty hit", int'(hit_cnt), 0);
    photon_fall();
    repeat (2) @(posedge clk);
    photon_rise(16'h0003);
    chk("after empty trig", int'(trig), 1);
    chk("after empty hit", int'(hit_cnt), 2);
    gate_width(w);
    chk("after empty width", w, 3);
    photon_fall();
    do_reset();

    // Retrigger while trig=1 is ignored.
    photon_rise(16'h000F);
    chk("retrig first hit", int'(hit_cnt), 4);
    gate_width(w);
    photon_fall();
    repeat (2) @(posedge clk);
    photon_rise(16'h0007);
    chk("retrig hit kept", int'(hit_cnt), 4);
    chk("retrig trig kept", int'(trig), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("retrig no new gate", int'(time_gate), 0);
    photon_fall();
    do_reset();

    // Reset while the gate is open.
    photon_rise(16'h0101);
    @(posedge clk);
    #1;
    chk("midgate gate open", int'(time_gate), 1);
    @(negedge clk);
    rst_auto = 1'b0;
    #1;
    chk("midgate trig drop", int'(trig), 0);
    chk("midgate gate drop", int'(time_gate), 0);
    chk("midgate hit drop", int'(hit_cnt), 0);
    photon = 1'b0;
    @(posedge clk);
    #1 rst_auto = 1'b1;
    repeat (4) @(posedge clk);
    photon_rise(16'hFFFF);
    chk("post midgate hit", int'(hit_cnt), 16);
    chk("post midgate gate", int'(time_gate), 1);
    gate_width(w);
    chk("post midgate width", w, 3);
    photon_fall();
    do_reset();

    // GATE_CYCLES=4 instance: SYNC_STAGES+GATE_CYCLES = 6 edges (+1 alignment).
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    spaden4 = 16'h00F0;
    photon4 = 1'b1;
    #1;
    chk("g4 trig", int'(trig4), 1);
    chk("g4 hit", int'(hit_cnt4), 4);
    w = 0;
    while (w < 20) begin
      @(posedge clk);
      #1;
      w++;
      if (!time_gate4) break;
    end
    chk_range("g4 gate width", w, 6, 7);
    chk("g4 trig holds", int'(trig4), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
